// File: rtl/pc_clk_gen.sv
// Programmable clock divider / phase generator driven entirely from clk_in.
// Produces a registered divided clock, rise/fall/last-cycle strobes and a period counter.
module pc_clk_gen #(
  parameter int CNT_W        = 4,
  parameter int DIV_DEFAULT  = 4,
  parameter int HIGH_DEFAULT = 2,
  parameter int PCNT_W       = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [CNT_W-1:0]  div_in,
  input  logic [CNT_W-1:0]  high_in,
  input  logic              hold,
  output logic              clk_out,
  output logic              tick_rise,
  output logic              tick_fall,
  output logic              last_cyc,
  output logic [CNT_W-1:0]  phase,
  output logic [PCNT_W-1:0] period_cnt
);

  // Reset defaults go through the same clamping as runtime loads.
  localparam int DIV_C  = (DIV_DEFAULT < 2) ? 2 : DIV_DEFAULT;
  localparam int HIGH_C = (HIGH_DEFAULT == 0) ? 1 :
                          (HIGH_DEFAULT >= DIV_C) ? DIV_C - 1 : HIGH_DEFAULT;
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DIV_C);
  localparam logic [CNT_W-1:0] HIGH_RST = CNT_W'(HIGH_C);

  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    if (d < CNT_W'(2)) return CNT_W'(2);
    return d;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_hi(input logic [CNT_W-1:0] h,
                                                 input logic [CNT_W-1:0] d);
    if (h == '0)  return CNT_W'(1);
    if (h >= d)   return d - CNT_W'(1);
    return h;
  endfunction

  logic [CNT_W-1:0]  ctr_q, ctr_d;
  logic [CNT_W-1:0]  div_act_q, div_act_d;
  logic [CNT_W-1:0]  hi_act_q, hi_act_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              clk_q, clk_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              last_q, last_d;
  logic              wrap;

  assign wrap = (ctr_q == div_act_q - CNT_W'(1));

  always_comb begin
    ctr_d     = ctr_q;
    div_act_d = div_act_q;
    hi_act_d  = hi_act_q;
    pcnt_d    = pcnt_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    if (!hold) begin
      if (wrap) begin
        // New settings only ever take effect at a period boundary.
        ctr_d     = '0;
        div_act_d = clamp_div(div_in);
        hi_act_d  = clamp_hi(high_in, div_act_d);
        pcnt_d    = pcnt_q + PCNT_W'(1);
        rise_d    = 1'b1;
      end else begin
        ctr_d  = ctr_q + CNT_W'(1);
        fall_d = (ctr_d == hi_act_q);
      end
    end
    // Output flops are decoded from next-state so they change cleanly with ctr.
    clk_d  = (ctr_d < hi_act_d);
    last_d = (ctr_d == div_act_d - CNT_W'(1));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      ctr_q     <= '0;
      div_act_q <= DIV_RST;
      hi_act_q  <= HIGH_RST;
      pcnt_q    <= '0;
      clk_q     <= 1'b1;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      div_act_q <= div_act_d;
      hi_act_q  <= hi_act_d;
      pcnt_q    <= pcnt_d;
      clk_q     <= clk_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      last_q    <= last_d;
    end
  end

  assign clk_out    = clk_q;
  assign tick_rise  = rise_q;
  assign tick_fall  = fall_q;
  assign last_cyc   = last_q;
  assign phase      = ctr_q;
  assign period_cnt = pcnt_q;

endmodule

// File: doc/pc_clk_gen.md
# pc_clk_gen

Parametrised, runtime-programmable clock divider and phase generator for the processor core; the next generation of the fixed divide-by-4 PC clock. It derives a slow, glitch-free clock `clk_out` from `clk_in` with programmable period and high time, and provides single-cycle rise/fall/last-cycle strobes and a period counter. Stage logic can run on `clk_in` with enables instead of on a derived clock. It sits between the board clock and the PC/datapath registers and supports hold (stall) without losing phase.

## Interface
- `CNT_W`, 4: width of the phase counter and of the `div_in`/`high_in` fields; maximum period 2^CNT_W − 1.
- `DIV_DEFAULT`, 4: period in `clk_in` cycles loaded at reset, clamped as `div_in`.
- `HIGH_DEFAULT`, 2: high time loaded at reset, clamped as `high_in`.
- `PCNT_W`, 16: width of `period_cnt`.

Ports:
- `clk_in`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `div_in`  in  CNT_W  requested period in `clk_in` cycles.
- `high_in`  in  CNT_W  requested high time in `clk_in` cycles.
- `hold`  in  1  freeze: phase, outputs and period count do not advance.
- `clk_out`  out  1  divided clock, registered.
- `tick_rise`  out  1  one-cycle strobe, the first cycle of the high phase.
- `tick_fall`  out  1  one-cycle strobe, the first cycle of the low phase.
- `last_cyc`  out  1  high while `ctr` equals `div_act` − 1, the final cycle of a period.
- `phase`  out  CNT_W  current counter value `ctr`.
- `period_cnt`  out  PCNT_W  completed periods, wraps modulo 2^PCNT_W.

## Operation
- State: `ctr`, `div_act`, `hi_act`, and the output flops.
- Clamping is applied on every load:
  - div_eff = 2 if `div_in` < 2, else `div_in`.
  - hi_eff = 1 if `high_in` = 0; div_eff − 1 if `high_in` ≥ div_eff; else `high_in`.
  - The parameter defaults use the same rules.
- Advance happens when `hold`=0.
  - ctr_next = 0 if `ctr` = `div_act` − 1, else `ctr` + 1.
  - With `hold`=1, `ctr` holds.
- Reload happens only on an advancing wrap (`ctr` = `div_act` − 1 and `hold`=0).
  - `div_act` and `hi_act` take the clamped `div_in`/`high_in` and apply from the new `ctr`=0.
  - Input changes mid-period are ignored until the boundary.
  - No reload happens while held.
- `clk_out` is a flop. After every edge, `clk_out` = (`ctr` < `hi_act`) using the current registered values, computed from next-state values so there is no decode glitch.
- `tick_rise` and `tick_fall` are flops that are 1 only in the cycle after an advancing edge:
  - `tick_rise`: the edge moved `ctr` to 0.
  - `tick_fall`: the edge moved `ctr` to `hi_act`.
  - Both are 0 in held cycles, so strobes never repeat during `hold`.
- `last_cyc` = (`ctr` = `div_act` − 1), registered alongside `ctr`; it stays asserted while held in that state.
- `period_cnt` increments on each advancing wrap and wraps from all-ones to 0.
- Reset (any cycle, including mid-period or during `hold`), next edge:
  - `ctr`=0, `div_act`/`hi_act` = clamped defaults, `clk_out`=1.
  - `tick_rise`=0, `tick_fall`=0, `last_cyc`=0, `period_cnt`=0.
  - `div_in`/`high_in` are not sampled.
  - `rst` dominates `hold`.

## Timing
- Latency: every output is valid one `clk_in` edge after the state change; no combinational input-to-output path.
- Default sequence after reset release (DIV=4, HIGH=2):

  | signal | values per cycle |
  |---|---|
  | `ctr` | 0,1,2,3,0,1… |
  | `clk_out` | 1,1,0,0,1,1… |
  | `tick_fall` | 0,0,1,0,0… |
  | `tick_rise` | 0,0,0,0,1… |
  | `last_cyc` | 0,0,0,1,0… |

- Reset cycle carries no `tick_rise`. The first `tick_rise` is at the first wrap.
- New `div_in`/`high_in` take effect on the period that begins immediately after the boundary edge.
- A hold of N cycles stretches the current phase by exactly N cycles.

## Test plan
- **Reset defaults.** Reset 3 cycles, release, `div_in`=4, `high_in`=2 → `clk_out` 1,1,0,0 repeating; `tick_fall` at `ctr`=2; `tick_rise` at `ctr`=0; `period_cnt` 0→1 at cycle 4.
- **Mid-period reprogram.** Change to `div_in`=7, `high_in`=3 at `ctr`=1 → remainder of the current period stays 4/2; next period is 3 high, 4 low; `tick_fall` at `ctr`=3.
- **Clamping.** `div_in`=0, `high_in`=0 → period 2, `clk_out` 1,0. `div_in`=5, `high_in`=9 → 4 high, 1 low.
- **Hold at boundary.** Assert `hold` for 3 cycles while `ctr`=3 and change `div_in`, then release → `clk_out` stays 0, `last_cyc` stays 1, no strobes, no reload during hold; reload and `tick_rise` on the first edge after release.
- **Reset mid-operation.** Assert `rst` at `ctr`=2 with `div_in`=9 → next cycle `ctr`=0, `clk_out`=1, `period_cnt`=0, period 4 (default, not 9).
- **Period counter wrap.** `PCNT_W`=3, run 9 periods → `period_cnt` 7→0→1.
